spi_txn_arbiter: RTL

Shares one spi_master engine between NUM_REQ requesters using round-robin arbitration.
Sequences multi-byte transactions as a series of single-byte engine transfers, and routes transmit and receive bytes to and from the winning requester.
Drives a dedicated active-low chip select per requester, held low for the whole transaction.
Sits between the client blocks and the single spi_master instance.

---
 rtl/spi_txn_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_master across NUM_REQ clients.
// Define SPI_ARB_TIMEOUT_EN to build the per-byte WAIT watchdog and err.
module spi_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int LEN_W          = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [2*NUM_REQ-1:0]       req_mode,
    input  logic [LEN_W*NUM_REQ-1:0]   req_len,
    input  logic [8*NUM_REQ-1:0]       tx_data,
    output logic [NUM_REQ-1:0]         tx_ack,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    output logic [$clog2(NUM_REQ)-1:0] rx_id,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         txn_done,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         dev_cs_n,
    output logic                       spi_start,
    output logic [7:0]                 spi_data,
    output logic [1:0]                 spi_mode,
    input  logic                       spi_done,
    input  logic [7:0]                 spi_rx,
    output logic                       err
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, GRANT, LAUNCH, WAIT, GAP, FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [1:0]         mode_q, mode_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         spi_data_q, spi_data_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic [IDX_W-1:0]   rx_id_q, rx_id_d;
    logic               rx_valid_q, rx_valid_d;
    logic               done_prev_q;
    logic               done_rise;
    logic               found;
    logic [IDX_W-1:0]   pick, cand;
    logic [NUM_REQ-1:0] onehot;
    logic               owned;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    assign done_rise = spi_done & ~done_prev_q;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_d       = rr_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        spi_data_d = spi_data_q;
        rx_data_d  = rx_data_q;
        rx_id_d    = rx_id_q;
        rx_valid_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d  = (state_q == WAIT) ? wd_q + 1'b1 : '0;
        err_d = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = pick;
                    mode_d  = req_mode[2*int'(pick) +: 2];
                    cnt_d   = req_len[LEN_W*int'(pick) +: LEN_W];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                spi_data_d = tx_data[8*int'(idx_q) +: 8];
                state_d    = LAUNCH;
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (done_rise) begin
                    rx_data_d  = spi_rx;
                    rx_id_d    = idx_q;
                    rx_valid_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        if (GAP_CYCLES == 0) begin
                            spi_data_d = tx_data[8*int'(idx_q) +: 8];
                            state_d    = LAUNCH;
                        end else begin
                            gap_d   = '0;
                            state_d = GAP;
                        end
                    end
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
`endif
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    spi_data_d = tx_data[8*int'(idx_q) +: 8];
                    state_d    = LAUNCH;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            FINISH: begin
                rr_d    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rr_q        <= '0;
            mode_q      <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            spi_data_q  <= '0;
            rx_data_q   <= '0;
            rx_id_q     <= '0;
            rx_valid_q  <= 1'b0;
            done_prev_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            spi_data_q  <= spi_data_d;
            rx_data_q   <= rx_data_d;
            rx_id_q     <= rx_id_d;
            rx_valid_q  <= rx_valid_d;
            done_prev_q <= spi_done;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    // Grant and CS share one decode so only one CS can ever be low.
    assign onehot = NUM_REQ'(1) << idx_q;
    assign owned  = (state_q == GRANT) || (state_q == LAUNCH) ||
                    (state_q == WAIT)  || (state_q == GAP);

    assign gnt       = owned ? onehot : '0;
    assign dev_cs_n  = ~gnt;
    assign spi_start = (state_q == LAUNCH);
    assign tx_ack    = spi_start ? onehot : '0;
    assign txn_done  = (state_q == FINISH) ? onehot : '0;
    assign busy      = (state_q != IDLE);
    assign spi_data  = spi_data_q;
    assign spi_mode  = mode_q;
    assign rx_data   = rx_data_q;
    assign rx_id     = rx_id_q;
    assign rx_valid  = rx_valid_q;

`ifdef SPI_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule
